// File: rtl/capture_ctrl.sv
// capture_ctrl: sequencing for a triggered capture RAM.
// Fills the pre-trigger window and arms, waits for a trigger, records the
// post-trigger samples, then reads the whole ring back oldest-first.
// The readout is paced by the host transmitter.
module capture_ctrl #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [LOG2-1:0] trig_pos,
  input  logic            wrt_smpl,
  input  logic            triggered,
  input  logic            dump,
  input  logic            tx_rdy,
  output logic            we,
  output logic [LOG2-1:0] waddr,
  output logic [LOG2-1:0] raddr,
  output logic            send,
  output logic            armed,
  output logic            capture_done,
  output logic [LOG2-1:0] trig_addr,
  output logic            dump_done
);

  localparam logic [LOG2:0]   ENT  = (LOG2+1)'(ENTRIES);
  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

  typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE, DWAIT, DUMP} state_t;

  state_t          state;
  logic [LOG2:0]   smpl_cnt, post_cnt, rd_cnt;
  logic [LOG2-1:0] tpos;
  logic [LOG2-1:0] tpos_clamped, waddr_nxt, raddr_nxt, tstart;
  logic [LOG2:0]   pre_target;
  logic            capturing;

  // Write strobe passes straight through while the ring is being filled.
  // The other terms are ring-pointer increments and the clamped trig_pos.
  always_comb begin
    capturing    = (state == PRE) || (state == ARMED) || (state == POST);
    we           = capturing && wrt_smpl;
    waddr_nxt    = (waddr == LAST) ? '0 : waddr + 1'b1;
    raddr_nxt    = (raddr == LAST) ? '0 : raddr + 1'b1;
    tstart       = (trig_addr == LAST) ? '0 : trig_addr + 1'b1;
    pre_target   = ENT - {1'b0, tpos};
    tpos_clamped = trig_pos;
    if (trig_pos == '0)
      tpos_clamped = {{(LOG2-1){1'b0}}, 1'b1};
    else if ({1'b0, trig_pos} >= ENT)
      tpos_clamped = LAST;
  end

  // Capture/readout FSM with registered status and handshake outputs.
  // run restarts from any state except an active readout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      waddr        <= '0;
      raddr        <= '0;
      trig_addr    <= '0;
      tpos         <= '0;
      smpl_cnt     <= '0;
      post_cnt     <= '0;
      rd_cnt       <= '0;
      armed        <= 1'b0;
      capture_done <= 1'b0;
      send         <= 1'b0;
      dump_done    <= 1'b0;
    end else begin
      send      <= 1'b0;
      dump_done <= 1'b0;
      if (run && state != DWAIT && state != DUMP) begin
        waddr        <= '0;
        smpl_cnt     <= '0;
        post_cnt     <= '0;
        armed        <= 1'b0;
        capture_done <= 1'b0;
        tpos         <= tpos_clamped;
        state        <= PRE;
      end else begin
        case (state)
          PRE: begin
            // triggers are not looked at until the pre-trigger window is full
            if (we) begin
              waddr    <= waddr_nxt;
              smpl_cnt <= smpl_cnt + 1'b1;
              if (smpl_cnt + 1'b1 == pre_target) begin
                armed <= 1'b1;
                state <= ARMED;
              end
            end
          end
          ARMED: begin
            // a sample written alongside the trigger belongs to the pre window
            if (we) waddr <= waddr_nxt;
            if (triggered) begin
              post_cnt <= '0;
              state    <= POST;
            end
          end
          POST: begin
            if (we) begin
              waddr    <= waddr_nxt;
              post_cnt <= post_cnt + 1'b1;
              if (post_cnt + 1'b1 == {1'b0, tpos}) begin
                trig_addr    <= waddr;
                capture_done <= 1'b1;
                armed        <= 1'b0;
                state        <= DONE;
              end
            end
          end
          DONE: begin
            // oldest sample sits just past the last post-trigger write
            if (dump) begin
              raddr        <= tstart;
              rd_cnt       <= '0;
              capture_done <= 1'b0;
              state        <= DWAIT;
            end
          end
          DWAIT: begin
            if (rd_cnt == ENT) begin
              dump_done <= 1'b1;
              state     <= IDLE;
            end else begin
              state <= DUMP;
            end
          end
          DUMP: begin
            if (tx_rdy) begin
              send   <= 1'b1;
              raddr  <= raddr_nxt;
              rd_cnt <= rd_cnt + 1'b1;
              state  <= DWAIT;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: randomized scoreboard bench for capture_ctrl.
// The driver derives each capture's write addresses, trigger address and
// readout order from the window arithmetic and queues them. A negedge
// monitor pops and compares whenever the DUT writes, completes or sends.
module tb_capture_ctrl;
  localparam int E = 384;
  localparam int L = 9;

  logic         clk = 1'b0;
  logic         rst, run, wrt_smpl, triggered, dump, tx_rdy;
  logic [L-1:0] trig_pos;
  logic         we, send, armed, capture_done, dump_done;
  logic [L-1:0] waddr, raddr, trig_addr;

  capture_ctrl #(.ENTRIES(E), .LOG2(L)) dut (
    .clk(clk), .rst(rst), .run(run), .trig_pos(trig_pos),
    .wrt_smpl(wrt_smpl), .triggered(triggered), .dump(dump), .tx_rdy(tx_rdy),
    .we(we), .waddr(waddr), .raddr(raddr), .send(send), .armed(armed),
    .capture_done(capture_done), .trig_addr(trig_addr), .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int wq[$];
  int tq[$];
  int sq[$];
  int done_cnt = 0;
  int n_send = 0;
  bit prev_send = 1'b0;
  bit prev_cd = 1'b0;
  bit prev_tx = 1'b0;
  int prev_ra = 0;

  task automatic ce(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int clamp_tp(input int tp);
    return (tp == 0) ? 1 : ((tp >= E) ? E - 1 : tp);
  endfunction

  // last write index of a capture with `a` writes between window fill and trigger
  function automatic int exp_ta(input int tp, input int a);
    return ((E - clamp_tp(tp)) + a + clamp_tp(tp) - 1) % E;
  endfunction

  function automatic bit noise(input int mode);
    if (mode == 2) return 1'b1;
    if (mode == 1) return ($urandom_range(3, 0) == 0);
    return 1'b0;
  endfunction

  // monitor: compare DUT activity against queued expectations
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (we) begin
          if (wq.size() == 0) ce("we_unexpected", 1, 0);
          else begin e = wq.pop_front(); ce("waddr", int'(waddr), e); end
        end
        if (capture_done && !prev_cd) begin
          if (tq.size() == 0) ce("done_unexpected", 1, 0);
          else begin e = tq.pop_front(); ce("trig_addr", int'(trig_addr), e); end
        end
        if (send) begin
          ce("send_needs_tx_rdy", int'(prev_tx), 1);
          ce("send_spacing", int'(prev_send), 0);
          if (sq.size() == 0) ce("send_unexpected", 1, 0);
          else begin e = sq.pop_front(); ce("send_addr", prev_ra, e); end
          n_send++;
        end
        if (dump_done) begin
          ce("dump_done_all_sent", sq.size(), 0);
          ce("dump_done_after_send", int'(prev_send), 1);
          done_cnt++;
        end
      end
      prev_send = send;
      prev_cd   = capture_done;
      prev_tx   = tx_rdy;
      prev_ra   = int'(raddr);
    end
  end

  // reset (with run and dump also high) and check every reset value
  task automatic reset_seq;
    rst = 1; run = 1; dump = 1; wrt_smpl = 1; triggered = 0; tx_rdy = 0;
    tick;
    rst = 0; run = 0; dump = 0;
    wq.delete(); tq.delete(); sq.delete();
    ce("rst_waddr", int'(waddr), 0);
    ce("rst_raddr", int'(raddr), 0);
    ce("rst_trig_addr", int'(trig_addr), 0);
    ce("rst_armed", int'(armed), 0);
    ce("rst_capture_done", int'(capture_done), 0);
    ce("rst_send", int'(send), 0);
    ce("rst_dump_done", int'(dump_done), 0);
    ce("rst_we", int'(we), 0);
    tick;
    ce("rst_beats_run_we", int'(we), 0);
    wrt_smpl = 0;
  endtask

  task automatic capture(input int tp, input int a, input int gmax,
                         input int tmode, input int abort_at);
    int tpc, pre, total;
    tpc = clamp_tp(tp); pre = E - tpc; total = pre + a + tpc;
    tq.push_back((total - 1) % E);
    trig_pos = L'(tp); run = 1; wrt_smpl = 0; triggered = 0;
    tick;
    run = 0;
    ce("run_waddr", int'(waddr), 0);
    ce("run_armed", int'(armed), 0);
    ce("run_capture_done", int'(capture_done), 0);
    for (int i = 0; i < total; i++) begin
      int g;
      g = $urandom_range(gmax, 0);
      if (i == abort_at) begin
        void'(tq.pop_back());
        ce("abort_no_done", int'(capture_done), 0);
        return;
      end
      repeat (g) begin
        wrt_smpl = 0; triggered = (i < pre) && noise(tmode); tick;
      end
      wq.push_back(i % E);
      wrt_smpl = 1;
      triggered = (i == pre + a - 1) || ((i < pre) && noise(tmode));
      tick;
      if (i == pre - 2) ce("armed_before_fill", int'(armed), 0);
      if (i == pre - 1) ce("armed_rise", int'(armed), 1);
    end
    wrt_smpl = 0; triggered = 0;
    tick;
    ce("capture_done", int'(capture_done), 1);
    ce("armed_clear_done", int'(armed), 0);
    ce("trig_addr_final", int'(trig_addr), (total - 1) % E);
  endtask

  task automatic do_dump(input int ta, input int txmode, input bit stall, input int rst_after);
    int start, c, r0, n0;
    bit stalled;
    for (int i = 0; i < E; i++) sq.push_back((ta + 1 + i) % E);
    n_send = 0; start = done_cnt; stalled = 0; c = 0;
    dump = 1; tx_rdy = 0;
    tick;
    dump = 0;
    ce("dump_raddr", int'(raddr), (ta + 1) % E);
    ce("dump_clears_done", int'(capture_done), 0);
    while (done_cnt == start && c < 20000) begin
      if (stall && !stalled && n_send >= 100) begin
        stalled = 1; tx_rdy = 0;
        tick;
        r0 = int'(raddr); n0 = n_send;
        repeat (19) tick;
        ce("stall_raddr", int'(raddr), r0);
        ce("stall_sends", n_send, n0);
      end
      tx_rdy = txmode ? 1'($urandom_range(1, 0)) : 1'b1;
      run = (txmode != 0) && (c == 30);
      tick;
      run = 0;
      c++;
      if (c == rst_after) begin
        reset_seq;
        return;
      end
    end
    tx_rdy = 0;
    ce("dump_done_seen", done_cnt - start, 1);
    ce("dump_send_count", n_send, E);
    wrt_smpl = 1;
    #1;
    ce("idle_after_dump_we", int'(we), 0);
    wrt_smpl = 0;
  endtask

  initial begin
    int tp, a;
    rst = 1; run = 0; dump = 0; wrt_smpl = 0; triggered = 0; tx_rdy = 0; trig_pos = '0;
    tick; tick;
    reset_seq;
    dump = 1; tick; dump = 0;
    repeat (5) tick;
    ce("idle_dump_ignored_raddr", int'(raddr), 0);

    capture(128, 44, 0, 0, -1);
    ce("normal_trig_addr", int'(trig_addr), 43);
    do_dump(43, 0, 1'b0, -1);

    capture(128, 1, 0, 2, -1);
    ce("held_trig_trig_addr", int'(trig_addr), 0);
    do_dump(0, 1, 1'b1, -1);

    capture(100, 20, 2, 1, 150);
    capture(200, 10, 2, 1, 184 + 10 + 5);
    capture(0, 5, 2, 1, -1);
    do_dump(exp_ta(0, 5), 1, 1'b0, -1);
    capture(500, 3, 2, 1, -1);
    do_dump(exp_ta(500, 3), 1, 1'b0, -1);

    for (int r = 0; r < 3; r++) begin
      tp = $urandom_range(511, 0);
      a  = $urandom_range(60, 1);
      capture(tp, a, 2, 1, -1);
      do_dump(exp_ta(tp, a), 1, r == 0, -1);
    end

    capture(64, 10, 1, 1, -1);
    do_dump(exp_ta(64, 10), 1, 1'b0, 50);
    capture(64, 10, 0, 0, -1);
    do_dump(exp_ta(64, 10), 0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
